// File: rtl/rect_obstacle_v2.sv
// Movable rectangle obstacle: button-driven or bouncing horizontal patrol, with
// registered player movement permits computed against the full rectangle extent.
module rect_obstacle_v2 #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int RECT_W     = 128,
  parameter int RECT_H     = 12,
  parameter int PLAYER_SZ  = 12,
  parameter int STEP       = 1,
  parameter int H_START    = 0,
  parameter int V_START    = 0,
  parameter int PATROL_DIV = 4,
  parameter int CW         = 11
) (
  input  logic          btnClk,
  input  logic          rst,
  input  logic          mode,
  input  logic [3:0]    btns,
  input  logic          passable,
  input  logic [3:0]    player_color,
  input  logic [3:0]    rect_color,
  input  logic [CW-1:0] player_hPos,
  input  logic [CW-1:0] player_vPos,
  output logic [CW-1:0] rect_hPos,
  output logic [CW-1:0] rect_vPos,
  output logic [3:0]    rect_color_o,
  output logic          upEnable,
  output logic          downEnable,
  output logic          leftEnable,
  output logic          rightEnable
);

  localparam int CNT_W = (PATROL_DIV > 1) ? $clog2(PATROL_DIV) : 1;

  typedef logic [CW:0]      ext_t;
  typedef logic [CW-1:0]    pos_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {MANUAL, PAT_R, PAT_L} state_t;

  localparam ext_t L_STEP = ext_t'(STEP);
  localparam ext_t L_HMAX = ext_t'(SCREEN_W - RECT_W);
  localparam ext_t L_VMAX = ext_t'(SCREEN_H - RECT_H);
  localparam ext_t L_RW   = ext_t'(RECT_W);
  localparam ext_t L_RH   = ext_t'(RECT_H);
  localparam ext_t L_PS   = ext_t'(PLAYER_SZ);
  localparam cnt_t L_CNT_LAST = cnt_t'(PATROL_DIV - 1);

  state_t r_state;
  cnt_t   r_cnt;
  pos_t   r_h, r_v;
  logic   r_up, r_down, r_left, r_right;

  ext_t w_h, w_v, w_ph, w_pv;
  pos_t w_v_up, w_v_dn, w_h_rt, w_h_lt, w_h_pr, w_h_pl;
  logic w_pr_edge, w_pl_edge;
  logic w_hov, w_vov, w_solid, w_trap;
  logic w_up_en, w_down_en, w_left_en, w_right_en;

  assign w_h  = {1'b0, r_h};
  assign w_v  = {1'b0, r_v};
  assign w_ph = {1'b0, player_hPos};
  assign w_pv = {1'b0, player_vPos};

  // Manual moves wrap to the opposite edge; patrol moves clamp and bounce.
  assign w_v_up    = (w_v >= L_STEP) ? pos_t'(w_v - L_STEP) : pos_t'(L_VMAX);
  assign w_v_dn    = (w_v + L_STEP <= L_VMAX) ? pos_t'(w_v + L_STEP) : '0;
  assign w_h_rt    = (w_h + L_STEP <= L_HMAX) ? pos_t'(w_h + L_STEP) : '0;
  assign w_h_lt    = (w_h >= L_STEP) ? pos_t'(w_h - L_STEP) : pos_t'(L_HMAX);
  assign w_pr_edge = !(w_h + L_STEP <= L_HMAX);
  assign w_pl_edge = !(w_h >= L_STEP);
  assign w_h_pr    = w_pr_edge ? pos_t'(L_HMAX) : pos_t'(w_h + L_STEP);
  assign w_h_pl    = w_pl_edge ? '0 : pos_t'(w_h - L_STEP);

  assign w_hov   = (w_ph < w_h + L_RW) && (w_ph + L_PS > w_h);
  assign w_vov   = (w_pv < w_v + L_RH) && (w_pv + L_PS > w_v);
  assign w_solid = !passable || (player_color != rect_color);
  assign w_trap  = w_solid && w_hov && w_vov;

  assign w_down_en  = !w_trap && !(w_solid && w_hov && (w_pv + L_PS == w_v));
  assign w_up_en    = !w_trap && !(w_solid && w_hov && (w_pv == w_v + L_RH));
  assign w_right_en = !w_trap && !(w_solid && w_vov && (w_ph + L_PS == w_h));
  assign w_left_en  = !w_trap && !(w_solid && w_vov && (w_ph == w_h + L_RW));

  always_ff @(posedge btnClk) begin
    if (!rst) begin
      r_state <= MANUAL;
      r_cnt   <= '0;
      r_h     <= pos_t'(H_START);
      r_v     <= pos_t'(V_START);
      r_up    <= 1'b1;
      r_down  <= 1'b1;
      r_left  <= 1'b1;
      r_right <= 1'b1;
    end else begin
      r_up    <= w_up_en;
      r_down  <= w_down_en;
      r_left  <= w_left_en;
      r_right <= w_right_en;
      case (r_state)
        MANUAL: begin
          if (mode) begin
            r_state <= PAT_R;
            r_cnt   <= '0;
          end else begin
            case (btns)
              4'b1000: r_v <= w_v_up;
              4'b0100: r_v <= w_v_dn;
              4'b0010: r_h <= w_h_rt;
              4'b0001: r_h <= w_h_lt;
              default: ;
            endcase
          end
        end
        PAT_R: begin
          if (!mode) begin
            r_state <= MANUAL;
          end else if (r_cnt == L_CNT_LAST) begin
            r_cnt <= '0;
            r_h   <= w_h_pr;
            if (w_pr_edge) r_state <= PAT_L;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PAT_L: begin
          if (!mode) begin
            r_state <= MANUAL;
          end else if (r_cnt == L_CNT_LAST) begin
            r_cnt <= '0;
            r_h   <= w_h_pl;
            if (w_pl_edge) r_state <= PAT_R;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= MANUAL;
      endcase
    end
  end

  assign rect_hPos    = r_h;
  assign rect_vPos    = r_v;
  assign rect_color_o = rect_color;
  assign upEnable     = r_up;
  assign downEnable   = r_down;
  assign leftEnable   = r_left;
  assign rightEnable  = r_right;

endmodule

// File: tb/tb_rect_obstacle_v2.sv
// Directed bench for rect_obstacle_v2: collision vector table plus manual-wrap,
// patrol-bounce and reset sequences.
module tb_rect_obstacle_v2;

  logic        clk = 1'b0;
  logic        rst, mode, passable;
  logic [3:0]  btns, player_color, rect_color, rect_color_o;
  logic [10:0] player_hPos, player_vPos, rect_hPos, rect_vPos;
  logic        upEnable, downEnable, leftEnable, rightEnable;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rect_obstacle_v2 #(.H_START(100), .V_START(200)) dut (
    .btnClk(clk), .rst(rst), .mode(mode), .btns(btns), .passable(passable),
    .player_color(player_color), .rect_color(rect_color),
    .player_hPos(player_hPos), .player_vPos(player_vPos),
    .rect_hPos(rect_hPos), .rect_vPos(rect_vPos), .rect_color_o(rect_color_o),
    .upEnable(upEnable), .downEnable(downEnable),
    .leftEnable(leftEnable), .rightEnable(rightEnable)
  );

  typedef struct {
    logic [10:0] ph, pv;
    logic        pas;
    logic [3:0]  pc, rc;
    logic [3:0]  en;   // {up, down, left, right}
  } vec_t;

  vec_t vecs[10];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pos(input string nm, input int h, input int v);
    chk({nm, ".h"}, 32'(rect_hPos), 32'(h));
    chk({nm, ".v"}, 32'(rect_vPos), 32'(v));
  endtask

  task automatic chk_en(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, upEnable, downEnable, leftEnable, rightEnable}, {28'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Rectangle at (100,200) spans h 100..228, v 200..212; player side 12.
    vecs[0] = '{ph: 150, pv: 188, pas: 1, pc: 1, rc: 2, en: 4'b1011};
    vecs[1] = '{ph: 150, pv: 188, pas: 1, pc: 3, rc: 3, en: 4'b1111};
    vecs[2] = '{ph: 150, pv: 188, pas: 0, pc: 3, rc: 3, en: 4'b1011};
    vecs[3] = '{ph:  88, pv: 200, pas: 1, pc: 1, rc: 2, en: 4'b1110};
    vecs[4] = '{ph: 228, pv: 200, pas: 1, pc: 1, rc: 2, en: 4'b1101};
    vecs[5] = '{ph:  88, pv: 188, pas: 1, pc: 1, rc: 2, en: 4'b1111};
    vecs[6] = '{ph: 150, pv: 205, pas: 1, pc: 1, rc: 2, en: 4'b0000};
    vecs[7] = '{ph: 150, pv: 212, pas: 0, pc: 5, rc: 5, en: 4'b0111};
    vecs[8] = '{ph: 150, pv: 205, pas: 1, pc: 7, rc: 7, en: 4'b1111};
    vecs[9] = '{ph:   0, pv:   0, pas: 0, pc: 1, rc: 2, en: 4'b1111};

    rst = 1'b0; mode = 1'b0; btns = 4'b1000; passable = 1'b1;
    player_color = 4'd1; rect_color = 4'd2;
    player_hPos = 11'd150; player_vPos = 11'd205;

    // Reset beats held button and an overlapping player.
    step(3);
    chk_pos("reset", 100, 200);
    chk_en("reset.en", 4'b1111);
    rst = 1'b1; btns = 4'b0000;

    foreach (vecs[i]) begin
      player_hPos = vecs[i].ph; player_vPos = vecs[i].pv; passable = vecs[i].pas;
      player_color = vecs[i].pc; rect_color = vecs[i].rc;
      #1;
      chk($sformatf("vec%0d.color", i), 32'(rect_color_o), 32'(vecs[i].rc));
      step(1);
      chk_en($sformatf("vec%0d.en", i), vecs[i].en);
      chk_pos($sformatf("vec%0d.pos", i), 100, 200);
    end

    player_hPos = 11'd1000; player_vPos = 11'd1000;

    // Manual moves and wrapping.
    btns = 4'b1000; step(200); btns = 4'b0000;
    chk_pos("up200", 100, 0);
    btns = 4'b1000; step(1); btns = 4'b0000;
    chk_pos("wrap_up", 100, 468);
    btns = 4'b0100; step(1); btns = 4'b0000;
    chk_pos("wrap_dn", 100, 0);
    btns = 4'b1100; step(2); btns = 4'b0000;
    chk_pos("multihot", 100, 0);
    btns = 4'b0100; step(200);
    btns = 4'b0010; step(410); btns = 4'b0000;
    chk_pos("to510", 510, 200);
    btns = 4'b0001; step(1);
    chk_pos("left1", 509, 200);
    btns = 4'b0010; step(1); btns = 4'b0000;

    // Patrol: transition cycle, then one move per 4 cycles, bounce at 512.
    mode = 1'b1; btns = 4'b1000;
    step(1);
    chk_pos("pat_enter", 510, 200);
    step(3);
    chk_pos("pat_3", 510, 200);
    step(1);
    chk_pos("pat_4", 511, 200);
    step(4);
    chk_pos("pat_8", 512, 200);
    step(4);
    chk_pos("pat_bounce", 512, 200);
    step(4);
    chk_pos("pat_back", 511, 200);

    // Leave patrol: position holds on the transition, then buttons work.
    mode = 1'b0;
    step(1);
    btns = 4'b0000;
    chk_pos("pat_exit", 511, 200);
    step(5);
    chk_pos("man_hold", 511, 200);
    btns = 4'b0010; step(1); btns = 4'b0000;
    chk_pos("man_right", 512, 200);

    // Trap: player inside rect at (512,200), colours differ.
    player_hPos = 11'd550; player_vPos = 11'd205; passable = 1'b1;
    player_color = 4'd1; rect_color = 4'd2;
    step(1);
    chk_en("trap", 4'b0000);
    player_hPos = 11'd1000; player_vPos = 11'd1000;
    step(1);
    chk_en("untrap", 4'b1111);

    // Reset in the middle of a patrol.
    mode = 1'b1;
    step(9);
    chk_pos("pat2", 511, 200);
    rst = 1'b0;
    step(1);
    chk_pos("mid_rst", 100, 200);
    chk_en("mid_rst.en", 4'b1111);
    rst = 1'b1; mode = 1'b0; btns = 4'b0010;
    step(1);
    btns = 4'b0000;
    chk_pos("rst_manual", 101, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_obstacle_v2.md
Name: rect_obstacle_v2

Overview:
- Parametrised movable rectangle obstacle for the VGA maze game.
- Holds the rectangle's absolute position, which is either button-driven (manual mode) or self-driven by a horizontal bounce patrol (patrol mode).
- Each cycle it computes registered up/down/left/right movement enables for the player against the full rectangle extent, with colour-match pass-through.
- Instantiated once per obstacle; enables from all instances are ANDed upstream.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- RECT_W, 128, rectangle width
- RECT_H, 12, rectangle height
- PLAYER_SZ, 12, player square side
- STEP, 1, pixels moved per move event (1..RECT_H)
- H_START, 0, reset horizontal position (must satisfy H_START <= SCREEN_W-RECT_W)
- V_START, 0, reset vertical position (must satisfy V_START <= SCREEN_H-RECT_H)
- PATROL_DIV, 4, cycles between patrol moves (>=1)
- CW, 11, coordinate width

Ports:
- btnClk  in  1  system/game clock
- rst  in  1  synchronous, active-low reset
- mode  in  1  0 = manual, 1 = patrol
- btns  in  4  one-hot {U,D,R,L} = {8,4,2,1}
- passable  in  1  1 = player may pass when colours match
- player_color  in  4  current player colour
- rect_color  in  4  this rectangle's colour
- player_hPos  in  CW  player left x
- player_vPos  in  CW  player top y
- rect_hPos  out  CW  rectangle left x (registered)
- rect_vPos  out  CW  rectangle top y (registered)
- rect_color_o  out  4  rect_color passed straight through (combinational)
- upEnable, downEnable, leftEnable, rightEnable  out  1 each  player movement permits (registered)

Behaviour:
- Reset (rst=0 at posedge btnClk):
  - rect_hPos=H_START, rect_vPos=V_START.
  - All four enables = 1.
  - FSM state = MANUAL, patrol counter = 0.
  - Reset wins over every other input, including mid-patrol.
- FSM states: MANUAL, PAT_R, PAT_L.
  - MANUAL, mode=1 -> PAT_R next cycle; counter cleared.
  - PAT_R/PAT_L, mode=0 -> MANUAL next cycle; position holds.
  - The mode change takes effect on the cycle after it is sampled; no move occurs on the transition cycle.
- MANUAL moves, one per cycle, only when btns is exactly one-hot; 0 or multi-hot btns means no move.
  - U: v = (v>=STEP) ? v-STEP : SCREEN_H-RECT_H (wrap to bottom).
  - D: v = (v+STEP <= SCREEN_H-RECT_H) ? v+STEP : 0 (wrap to top).
  - R: h = (h+STEP <= SCREEN_W-RECT_W) ? h+STEP : 0.
  - L: h = (h>=STEP) ? h-STEP : SCREEN_W-RECT_W.
- Patrol moves:
  - Counter increments every cycle. When it reaches PATROL_DIV-1 it clears and a move fires, so one move per PATROL_DIV cycles.
  - Buttons are ignored in patrol; vertical position is frozen.
  - PAT_R move: if h+STEP <= SCREEN_W-RECT_W then h += STEP; else h = SCREEN_W-RECT_W and state -> PAT_L.
  - PAT_L is symmetric: clamp at 0, then -> PAT_R.
  - Bouncing never wraps.
- Geometry, computed from the current registered rect position (pre-move) and the current player inputs:
  - hOv = player_hPos < h+RECT_W && player_hPos+PLAYER_SZ > h
  - vOv = player_vPos < v+RECT_H && player_vPos+PLAYER_SZ > v
  - solid = !passable || (player_color != rect_color)
  - All arithmetic is done at CW+1 bits so no sum overflows.
- Enables are registered and valid one cycle after their inputs:
  - downEnable = !(solid && hOv && player_vPos+PLAYER_SZ == v)
  - upEnable = !(solid && hOv && player_vPos == v+RECT_H)
  - rightEnable = !(solid && vOv && player_hPos+PLAYER_SZ == h)
  - leftEnable = !(solid && vOv && player_hPos == h+RECT_W)
  - Trap override: solid && hOv && vOv (player overlapping the rectangle) -> all four enables = 0.
  - A player touching only at a corner (no overlap on the other axis) is not blocked.
- Simultaneous move and collision in one cycle: enables use the pre-move position; the next cycle reflects the new position.

Test Plan:
- Reset with H_START=100, V_START=200 -> rect_hPos=100, rect_vPos=200, all enables 1; hold btns=8 while rst=0 -> no move.
- Manual wrap, v=0, btns=8 -> v=468. Then btns=4 at v=468 -> v=0. btns=12 (multi-hot) -> no change.
- Player h=150, v=188, rect h=100, v=200, colours differ -> downEnable=0, others 1. Same with colours equal and passable=1 -> downEnable=1. With passable=0 -> downEnable=0.
- Player h=88, v=200 (touching rect left side) -> rightEnable=0. Player h=228, v=200 -> leftEnable=0. Player h=88, v=188 (corner only) -> all enables 1.
- Patrol, PATROL_DIV=4, h starts at 510, STEP=1 -> h=511 after 4 cycles, 512 after 8, next move stays 512 and state flips to PAT_L, following move h=511. Drop mode to 0 mid-patrol -> h holds; btns=2 then moves it.
- Player at h=150, v=205 (inside rect), solid -> all four enables 0 one cycle later. Assert rst=0 mid-patrol -> position returns to H_START/V_START, state MANUAL.
